// File: rtl/hram_arbiter.sv
// Wishbone B4 N-to-1 arbiter sharing the HyperRAM controller data port.
// Optional stall watchdog: define ARB_TIMEOUT_EN (uses TIMEOUT).
//   state | meaning
//   IDLE  | no owner; arbitrate among m_cyc_i and register a one-hot grant
//   OWN   | granted master drives the slave port; ack/err routed to it only
module hram_arbiter #(
  parameter int NM        = 3,
  parameter int PRIO0     = 1,
  parameter int MAX_BEATS = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [32*NM-1:0]  m_adr_i,
  input  logic [32*NM-1:0]  m_dat_i,
  input  logic [4*NM-1:0]   m_sel_i,
  input  logic [3*NM-1:0]   m_cti_i,
  input  logic [2*NM-1:0]   m_bte_i,
  output logic [31:0]       m_dat_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [31:0]       s_adr_o,
  output logic [31:0]       s_dat_o,
  output logic [3:0]        s_sel_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [NM-1:0]     grant_o
);
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [NM-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d, cnt_inc;
  logic            cyc_g, stb_g, timeout_hit, release_ok;
  logic [2:0]      cti_g;
  logic [2*NM-1:0] req_rot;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  int              cand, sum;

  if (MAX_BEATS < 1 || MAX_BEATS > 255 || TIMEOUT < 1) begin : g_param_out_of_range
  end

  // grant_q is all-zero outside OWN, so the mux yields an idle slave port
  always_comb begin
    cyc_g   = 1'b0;
    stb_g   = 1'b0;
    cti_g   = 3'b000;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_bte_o = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant_q[k]) begin
        cyc_g   = m_cyc_i[k];
        stb_g   = m_stb_i[k];
        cti_g   = m_cti_i[3*k +: 3];
        s_we_o  = m_we_i[k];
        s_adr_o = m_adr_i[32*k +: 32];
        s_dat_o = m_dat_i[32*k +: 32];
        s_sel_o = m_sel_i[4*k +: 4];
        s_bte_o = m_bte_i[2*k +: 2];
      end
    end
  end

  assign s_cti_o = cti_g;
  assign s_cyc_o = cyc_g & ~timeout_hit;
  assign s_stb_o = stb_g & ~timeout_hit;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant_q & {NM{s_ack_i & ~timeout_hit}};
  assign m_err_o = grant_q & {NM{s_err_i | timeout_hit}};
  assign grant_o = grant_q;

  // rotate requests so bit 0 is the pointer position; lowest set bit wins
  always_comb begin
    req_rot   = {m_cyc_i, m_cyc_i} >> ptr_q;
    sel_found = |m_cyc_i;
    cand      = 0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (req_rot[i]) cand = i;
    end
    sum = int'(ptr_q) + cand;
    if (sum >= NM) sum = sum - NM;
    sel_idx = IW'(sum);
    if (PRIO0 != 0 && m_cyc_i[0]) sel_idx = '0;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    cnt_inc    = (s_ack_i && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    release_ok = (cti_g == 3'b000) || (cti_g == 3'b111);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel_found) begin
          state_d = OWN;
          grant_d = NM'(1) << sel_idx;
          if (!(PRIO0 != 0 && sel_idx == '0))
            ptr_d = (sel_idx == IW'(NM - 1)) ? '0 : sel_idx + 1'b1;
        end
      end
      OWN: begin
        cnt_d = cnt_inc;
        if (!cyc_g || timeout_hit ||
            (s_ack_i && release_ok && cnt_inc >= 8'(MAX_BEATS))) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_q, stall_d;

  assign timeout_hit = (state_q == OWN) && (stall_q == SW'(TIMEOUT));

  always_comb begin
    stall_d = stall_q;
    if (state_q != OWN || s_ack_i || timeout_hit)
      stall_d = '0;
    else if (stb_g)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) stall_q <= '0;
    else            stall_q <= stall_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
